// File: rtl/alu_sequencer.sv
// alu_sequencer: two-requester, single-slot ALU front end.
// Round-robin arbitration picks one request in IDLE; ADD/SUB/MUL/CMP and the
// error cases finish on the accept edge, while DIV runs on a 32-step restoring
// divider and answers 35 cycles after the accept.
// Build option: define ALU_SEQ_DIV_EN to include the divider; without it,
// opcode 100 is reported as an illegal operation.
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on anything but state, reset and req_valid.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DIV_START = 2'd1;
    localparam logic [1:0] S_DIV_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    // 8-bit carry-lookahead adder built from generate/propagate terms.
    function automatic logic [7:0] cla_add8(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < 7; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

    // Shift-and-add multiplier keeping only the low 8 product bits.
    function automatic logic [7:0] mul_lo8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = cla_add8(acc, a << i, 1'b0);
            end
        end
        return acc;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;

    logic        grant_vld;
    logic        grant_id;
    logic [2:0]  sel_op;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [7:0]  add_res;
    logic [7:0]  sub_res;
    logic [7:0]  mul_res;
    logic [1:0]  cmp_code;

`ifdef ALU_SEQ_DIV_EN
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;

    logic        div_rst_n;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_busy_q;
    logic        div_ready_q;
    logic [4:0]  div_cnt_q;
    logic [31:0] div_dvd_q;
    logic [15:0] div_rem_q;
    logic [15:0] div_dvs_q;
    logic [16:0] div_trial;
    logic [16:0] div_diff;
    logic        div_borrow;
`endif

    // Round-robin grant; only visible in IDLE and never during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            case (req_valid)
                2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;  end
                2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;  end
                2'b11:   begin grant_vld = 1'b1; grant_id = ptr_q; end
                default: begin grant_vld = 1'b0; grant_id = 1'b0;  end
            endcase
        end
        req_ready = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    end

    // Operand selection for the granted requester and single-cycle results.
    always_comb begin
        sel_op   = grant_id ? req_op[5:3] : req_op[2:0];
        sel_a    = grant_id ? req_a[15:8] : req_a[7:0];
        sel_b    = grant_id ? req_b[15:8] : req_b[7:0];
        add_res  = cla_add8(sel_a, sel_b, 1'b0);
        sub_res  = cla_add8(sel_a, ~sel_b, 1'b1);
        mul_res  = mul_lo8(sel_a, sel_b);
        // "Less than" is the sign bit of the 8-bit difference.
        if (sel_a == sel_b) begin
            cmp_code = 2'b00;
        end else if (sub_res[7]) begin
            cmp_code = 2'b01;
        end else begin
            cmp_code = 2'b10;
        end
    end

    // Sequencer next-state and response-register logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef ALU_SEQ_DIV_EN
        a_d     = a_q;
        b_d     = b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    id_d    = grant_id;
                    ptr_d   = ~grant_id;
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    case (sel_op)
                        OP_ADD: data_d = {8'h00, add_res};
                        OP_SUB: data_d = {8'h00, sub_res};
                        OP_MUL: data_d = {8'h00, mul_res};
                        OP_CMP: data_d = {14'b0, cmp_code};
                        OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                            if (sel_b == 8'h00) begin
                                data_d = {sel_a, 8'hFF};
                                err_d  = 1'b1;
                            end else begin
                                a_d     = sel_a;
                                b_d     = sel_b;
                                state_d = S_DIV_START;
                            end
`else
                            data_d = 16'h0000;
                            err_d  = 1'b1;
`endif
                        end
                        default: begin
                            data_d = 16'h0000;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_DIV_START: begin
`ifdef ALU_SEQ_DIV_EN
                state_d = S_DIV_WAIT;
`else
                state_d = S_IDLE;
`endif
            end
            S_DIV_WAIT: begin
`ifdef ALU_SEQ_DIV_EN
                if (div_ready_q && !div_busy_q) begin
                    data_d  = {div_rem_q[7:0], div_dvd_q[7:0]};
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    // Latched DIV operands, held for the divider start cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Divider interface and one restoring step (borrow means "does not fit").
    always_comb begin
        div_rst_n    = ~rst;
        div_start    = (state_q == S_DIV_START);
        div_dividend = {24'b0, a_q};
        div_divisor  = {8'b0, b_q};
        div_trial    = {div_rem_q, div_dvd_q[31]};
        div_diff     = div_trial - {1'b0, div_dvs_q};
        div_borrow   = div_diff[16];
    end

    // 32-step restoring divider; ready rises together with the last step.
    always_ff @(posedge clk) begin
        if (!div_rst_n) begin
            div_busy_q  <= 1'b0;
            div_ready_q <= 1'b0;
            div_cnt_q   <= 5'd0;
            div_dvd_q   <= 32'h0;
            div_rem_q   <= 16'h0;
            div_dvs_q   <= 16'h0;
        end else if (div_start) begin
            div_busy_q  <= 1'b1;
            div_ready_q <= 1'b0;
            div_cnt_q   <= 5'd0;
            div_dvd_q   <= div_dividend;
            div_rem_q   <= 16'h0;
            div_dvs_q   <= div_divisor;
        end else if (div_busy_q) begin
            div_rem_q <= div_borrow ? div_trial[15:0] : div_diff[15:0];
            div_dvd_q <= {div_dvd_q[30:0], ~div_borrow};
            div_cnt_q <= div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) begin
                div_busy_q  <= 1'b0;
                div_ready_q <= 1'b1;
            end
        end
    end
`endif

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random requests against a plain-arithmetic
// reference model; responses are matched through an expected queue.
module tb_alu_sequencer;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: {id, err, data} and the cycle the response must first appear
    logic [17:0] exp_q[$];
    int          due_q[$];
    logic        ptr_m;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: result straight from the arithmetic definitions.
    function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: begin r = (ia + ib) % 256;       return {1'b0, 16'(r)}; end
            3'd1: begin r = (ia - ib + 256) % 256; return {1'b0, 16'(r)}; end
            3'd2: begin r = (ia * ib) % 256;       return {1'b0, 16'(r)}; end
            3'd3: begin
                r = (ia - ib + 256) % 256;
                if (ia == ib) return 17'h00000;
                if (r >= 128) return 17'h00001;
                return 17'h00002;
            end
            3'd4: begin
                if (!DIV_EN) return {1'b1, 16'h0000};
                if (ib == 0) return {1'b1, a, 8'hFF};
                return {1'b0, 8'(ia % ib), 8'(ia / ib)};
            end
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [7:0] b);
        if (op == 3'd4 && DIV_EN && b != 8'h00) return 35;
        return 1;
    endfunction

    // driver + monitor: present requests on the masked ports and service all
    // responses, holding rsp_ready low for 'hold' cycles of each response.
    task automatic run_req(input logic [1:0] mask,
                           input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                           input int hold);
        logic [1:0]  pend;
        logic [1:0]  g_exp;
        logic [1:0]  acc;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] res;
        int          waited;
        int          got;
        int          want;
        bit          seen;
        pend   = mask;
        waited = 0;
        got    = 0;
        seen   = 1'b0;
        want   = int'(mask[0]) + int'(mask[1]);
        @(negedge clk);
        req_op    = {op1, op0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_valid = mask;
        for (int t = 0; t < 400 && (pend != 2'b00 || got < want); t++) begin
            #1;
            acc   = 2'b00;
            g_exp = 2'b00;
            if (exp_q.size() == 0 && pend != 2'b00) begin
                g_exp = (pend == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : pend;
            end
            check("req_ready", 24'(req_ready), 24'(g_exp));
            if (g_exp != 2'b00 && req_ready == g_exp) begin
                op  = g_exp[1] ? op1 : op0;
                a   = g_exp[1] ? a1 : a0;
                b   = g_exp[1] ? b1 : b0;
                res = model(op, a, b);
                exp_q.push_back({g_exp[1], res});
                due_q.push_back(cyc + latency(op, b));
                ptr_m = ~g_exp[1];
                acc   = g_exp;
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (exp_q.size() == 0 || acc != 2'b00) begin
                    check("rsp_unexpected", 24'(rsp_valid), 24'h0);
                end else begin
                    if (!seen) check("rsp_latency", 24'(cyc), 24'(due_q[0]));
                    seen = 1'b1;
                    check("rsp_content", 24'({rsp_id, rsp_err, rsp_data}), 24'(exp_q[0]));
                    if (waited >= hold) begin
                        rsp_ready = 1'b1;
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                        got++;
                        waited = 0;
                        seen   = 1'b0;
                    end else begin
                        waited++;
                    end
                end
            end
            @(posedge clk);
            #1;
            pend      = pend & ~acc;
            req_valid = pend;
            rsp_ready = 1'b0;
            @(negedge clk);
        end
        check("done_pending", 24'(pend), 24'h0);
        check("done_responses", 24'(got), 24'(want));
        exp_q.delete();
        due_q.delete();
    endtask

    // global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_spur;
        logic [1:0] mask;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = 6'h0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        ptr_m     = 1'b0;
        repeat (3) @(posedge clk);

        // reset state, with both requesters pushing
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("reset_outputs", 24'({req_ready, rsp_valid, rsp_id, rsp_err, rsp_data}), 24'h0);
        req_valid = 2'b00;
        rst       = 1'b0;

        // both valid CMP: pointer starts at requester 0
        run_req(2'b11, 3'd3, 8'd5, 8'd9, 3'd3, 8'd9, 8'd5, 0);
        // ADD wraps mod 256
        run_req(2'b01, 3'd0, 8'hF0, 8'h20, 3'd0, 8'h00, 8'h00, 0);
        // long divide on requester 1
        run_req(2'b10, 3'd0, 8'h00, 8'h00, 3'd4, 8'd200, 8'd7, 0);
        // divide by zero and an illegal opcode
        run_req(2'b01, 3'd4, 8'h33, 8'h00, 3'd0, 8'h00, 8'h00, 0);
        run_req(2'b01, 3'd6, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 0);
        // MUL with the consumer stalling 10 cycles
        run_req(2'b01, 3'd2, 8'd12, 8'd11, 3'd0, 8'h00, 8'h00, 10);
        // SUB and CMP boundaries from both ports
        run_req(2'b11, 3'd1, 8'h00, 8'h01, 3'd3, 8'h80, 8'h01, 1);

        // reset pulse while a DIV is outstanding
        @(negedge clk);
        req_op    = 6'b000_100;
        req_a     = {8'h00, 8'd200};
        req_b     = {8'h00, 8'd7};
        req_valid = 2'b01;
        #1;
        w = 0;
        while (req_ready != 2'b01 && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("mid_div_accept", 24'(req_ready), 24'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (10) @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        check("mid_div_reset_ready", 24'(req_ready), 24'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        ptr_m     = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", 24'({rsp_valid, rsp_id, rsp_err, rsp_data}), 24'h0);
        n_spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) n_spur++;
        end
        check("abandoned_div_silent", 24'(n_spur), 24'h0);
        run_req(2'b11, 3'd0, 8'h01, 8'h02, 3'd1, 8'h03, 8'h05, 0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            run_req(mask,
                    3'($urandom_range(0, 7)), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    3'($urandom_range(0, 7)), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  2  per-requester request strobe; bit i belongs to requester i.
REQ-004 req_ready  out  2  per-requester accept; a request is accepted when valid and ready are both high on one edge.
REQ-005 req_op  in  6  packed {op1,op0}, 3 bits each: 000 ADD, 001 SUB, 010 MUL, 011 CMP, 100 DIV, all others illegal.
REQ-006 req_a  in  16  packed {a1,a0}, 8-bit operand A per requester.
REQ-007 req_b  in  16  packed {b1,b0}, 8-bit operand B per requester.
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  response consumer accept.
REQ-010 rsp_id  out  1  index of the requester that owns the response.
REQ-011 rsp_data  out  16  result, formatted per REQ-017.
REQ-012 rsp_err  out  1  illegal opcode or divide-by-zero.

Function
REQ-013 States: IDLE, DIV_START, DIV_WAIT, RESP; the sequencer holds at most one operation in flight.
REQ-014 req_ready is zero outside IDLE; in IDLE only the granted requester sees req_ready=1, combinationally.
REQ-015 Arbitration is round-robin: pointer resets to 0; with both valid, the pointer's requester is granted; after any grant the pointer moves to the other requester; a single valid requester is always granted.
REQ-016 Accept edge latches op, A, B and id; ADD/SUB/MUL/CMP/illegal/DIV-by-zero results are registered on the same edge and the state goes to RESP, so rsp_valid rises 1 cycle after accept.
REQ-017 rsp_data: ADD, SUB, MUL = {8'h00, low 8 result bits}, mod 256, using the team carry-lookahead adder, two's-complement subtractor and multiplier; CMP = {14'b0, code} with 00 equal, 01 A<B, 10 A>B, where A<B is bit 7 of (A-B) mod 256; DIV = {remainder[7:0], quotient[7:0]}.
REQ-018 DIV with B≠0: accept goes to DIV_START, which drives divider start=1 for exactly one cycle with dividend {24'b0,A} and divisor {8'b0,B}; the state then goes to DIV_WAIT.
REQ-019 DIV_WAIT captures quotient and remainder on the first cycle with divider ready=1 and busy=0, then goes to RESP; rsp_valid first asserts 35 cycles after the accept cycle.
REQ-020 DIV with B=0 does not start the divider: rsp_data={A,8'hFF}, rsp_err=1, latency 1.
REQ-021 Illegal opcode: rsp_data=0, rsp_err=1, latency 1; for all legal non-zero-divisor operations rsp_err=0.
REQ-022 In RESP, rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1; the handshake edge returns the state to IDLE, and the next accept occurs no earlier than the following cycle.
REQ-023 req_valid deasserting while not granted has no effect; operands are not re-sampled after accept.

Reset
REQ-024 rst=1 at any edge, including mid-DIV, forces IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, pointer=0, and req_ready=0 during reset.
REQ-025 The divider's active-low reset is driven from ~rst, so an in-flight division is abandoned and no response is produced for it.

Configuration
REQ-026 Macro ALU_SEQ_DIV_EN defined: divider instantiated, DIV behaves per REQ-018 to REQ-020.
REQ-027 ALU_SEQ_DIV_EN undefined: no divider instantiated, DIV_START and DIV_WAIT unreachable, and opcode 100 is handled as illegal per REQ-021.

Verification
REQ-028 req0 ADD A=8'hF0 B=8'h20 -> 1 cycle later rsp_valid=1, rsp_data=16'h0010, rsp_id=0, rsp_err=0.
REQ-029 Both requesters valid with CMP: req0 A=5 B=9 and req1 A=9 B=5, rsp_ready=1 -> first response id=0 data=16'h0001, second id=1 data=16'h0002.
REQ-030 req1 DIV A=8'd200 B=8'd7 (macro defined) -> rsp_valid at accept+35, rsp_data=16'h041C, and req_ready=0 throughout.
REQ-031 DIV A=8'h33 B=0 -> 1 cycle later rsp_data=16'h33FF, rsp_err=1; op=3'b110 -> rsp_data=0, rsp_err=1.
REQ-032 rsp_ready held low for 10 cycles after MUL A=12 B=11 -> rsp_data=16'h0084 stable throughout; rst pulse mid-DIV -> IDLE next cycle, no response, new ADD then completes correctly.
